// File: rtl/iob_ram_2p_be_arb_pkg.sv
// Shared constants and the round-robin pick helper for the two-master RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iob_ram_2p_be_arb_pkg;

  localparam int N_REQ  = 2;
  localparam int BYTE_W = 8;

  // Winning index among two candidates: with both requesting, the one that did
  // not win last time; with one requesting, that one (0 when none request).
  function automatic logic rr_pick(input logic [1:0] cand, input logic last);
    logic idx;
    if (cand == 2'b11) idx = ~last;
    else               idx = cand[1];
    return idx;
  endfunction

endpackage

// File: rtl/iob_rr_arb2.sv
// Two-input round-robin arbiter with a last-grant pointer gated by en.
// Latency: grant is combinational from req and the pointer; pointer moves on the next edge.
// Backpressure: en = 0 freezes the pointer so a withheld grant does not cost fairness.
module iob_rr_arb2
  import iob_ram_2p_be_arb_pkg::*;
(
  input  logic       clk,
  input  logic       arst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_idx,
  output logic       gnt_any
);

  logic last;

  // Pick the winner from the current requests and the last-grant pointer.
  always_comb begin
    gnt_idx = rr_pick(req, last);
    gnt_any = |req;
    gnt     = {gnt_any & gnt_idx, gnt_any & ~gnt_idx};
  end

  // Remember who won, but only when the grant is actually taken.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)             last <= 1'b1;
    else if (en && gnt_any)  last <= gnt_idx;
  end

endmodule

// File: rtl/iob_ram_2p_be_arb.sv
// Shares one byte-enabled 2-port RAM between two masters; write and read ports arbitrated independently.
// Latency: write lands at the accepting edge; read data returns one cycle after acceptance.
// Backpressure: req_ready is combinational; a read colliding with a same-address write waits for it.
module iob_ram_2p_be_arb
  import iob_ram_2p_be_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                              clk,
  input  logic                              arst_n,
  input  logic [N_REQ-1:0]                  req_valid,
  input  logic [N_REQ-1:0]                  req_we,
  input  logic [N_REQ*ADDR_W-1:0]           req_addr,
  input  logic [N_REQ*DATA_W-1:0]           req_wdata,
  input  logic [N_REQ*(DATA_W/BYTE_W)-1:0]  req_wstrb,
  output logic [N_REQ-1:0]                  req_ready,
  output logic [N_REQ-1:0]                  rsp_rvalid,
  output logic [DATA_W-1:0]                 rsp_rdata,
  output logic [DATA_W/BYTE_W-1:0]          ram_w_en,
  output logic [ADDR_W-1:0]                 ram_w_addr,
  output logic [DATA_W-1:0]                 ram_w_data,
  output logic                              ram_r_en,
  output logic [ADDR_W-1:0]                 ram_r_addr,
  input  logic [DATA_W-1:0]                 ram_r_data
);

  localparam int STRB_W = DATA_W / BYTE_W;

  logic [N_REQ-1:0]  wr_req, rd_req, wr_gnt, rd_gnt;
  logic              wr_idx, rd_idx, wr_any, rd_any;
  logic              hazard, rd_go;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic [N_REQ-1:0]  rd_owner;

  // Candidates per port; forced idle while reset is asserted so no enable leaks out.
  always_comb begin
    wr_req = req_valid &  req_we & {N_REQ{arst_n}};
    rd_req = req_valid & ~req_we & {N_REQ{arst_n}};
  end

  iob_rr_arb2 u_wr_arb (
    .clk     (clk),
    .arst_n  (arst_n),
    .req     (wr_req),
    .en      (1'b1),
    .gnt     (wr_gnt),
    .gnt_idx (wr_idx),
    .gnt_any (wr_any)
  );

  iob_rr_arb2 u_rd_arb (
    .clk     (clk),
    .arst_n  (arst_n),
    .req     (rd_req),
    .en      (~hazard),
    .gnt     (rd_gnt),
    .gnt_idx (rd_idx),
    .gnt_any (rd_any)
  );

  // Select the winners' fields and detect a same-cycle read of the address being written.
  always_comb begin
    wr_addr = wr_idx ? req_addr[ADDR_W +: ADDR_W]  : req_addr[0 +: ADDR_W];
    wr_data = wr_idx ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
    wr_strb = wr_idx ? req_wstrb[STRB_W +: STRB_W] : req_wstrb[0 +: STRB_W];
    rd_addr = rd_idx ? req_addr[ADDR_W +: ADDR_W]  : req_addr[0 +: ADDR_W];
    hazard  = wr_any && rd_any && (wr_idx != rd_idx) && (wr_addr == rd_addr);
    rd_go   = rd_any && !hazard;
  end

  // Drive the RAM ports and the per-master accepts.
  always_comb begin
    req_ready  = wr_gnt | (rd_gnt & {N_REQ{~hazard}});
    ram_w_en   = wr_any ? wr_strb : '0;
    ram_w_addr = wr_addr;
    ram_w_data = wr_data;
    ram_r_en   = rd_go;
    ram_r_addr = rd_addr;
    rsp_rvalid = rd_owner;
    rsp_rdata  = ram_r_data;
  end

  // Track which master owns the read data arriving next cycle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) rd_owner <= '0;
    else         rd_owner <= rd_go ? rd_gnt : '0;
  end

endmodule

// File: tb/tb_iob_ram_2p_be_arb.sv
module tb_iob_ram_2p_be_arb;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            arst_n;
  logic [1:0]      req_valid, req_we, req_ready, rsp_rvalid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [2*SW-1:0] req_wstrb;
  logic [DW-1:0]   rsp_rdata, ram_w_data, ram_r_data;
  logic [SW-1:0]   ram_w_en;
  logic [AW-1:0]   ram_w_addr, ram_r_addr;
  logic            ram_r_en;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] exp_mem [0:(1<<AW)-1];
  logic [DW-1:0] sb [$];
  logic [1:0]    exp_rv = 2'b00;

  always #5 clk = ~clk;

  iob_ram_2p_be_arb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .req_ready  (req_ready),
    .rsp_rvalid (rsp_rvalid),
    .rsp_rdata  (rsp_rdata),
    .ram_w_en   (ram_w_en),
    .ram_w_addr (ram_w_addr),
    .ram_w_data (ram_w_data),
    .ram_r_en   (ram_r_en),
    .ram_r_addr (ram_r_addr),
    .ram_r_data (ram_r_data)
  );

  // Behavioural byte-enabled RAM with a registered read.
  always @(posedge clk) begin
    for (int b = 0; b < SW; b++)
      if (ram_w_en[b]) mem[ram_w_addr][b*8 +: 8] <= ram_w_data[b*8 +: 8];
    if (ram_r_en) ram_r_data <= mem[ram_r_addr];
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic set_req(input int m, input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_valid[m]          = v;
    req_we[m]             = we;
    req_addr[m*AW +: AW]  = a;
    req_wdata[m*DW +: DW] = d;
    req_wstrb[m*SW +: SW] = s;
  endtask

  task automatic idle();
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: responses checked first, then this cycle's accepts are recorded.
  always @(negedge clk) begin
    logic [1:0] nxt;
    nxt = 2'b00;
    if (!arst_n) begin
      chk("rvalid_in_reset", {62'd0, rsp_rvalid}, 64'd0);
      sb.delete();
      exp_rv = 2'b00;
    end else begin
      chk("rvalid", {62'd0, rsp_rvalid}, {62'd0, exp_rv});
      if (exp_rv != 2'b00) begin
        if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
        else chk("rdata", {32'd0, rsp_rdata}, {32'd0, sb.pop_front()});
      end
      for (int r = 0; r < 2; r++) begin
        if (req_valid[r] && req_ready[r]) begin
          if (req_we[r]) begin
            for (int b = 0; b < SW; b++)
              if (req_wstrb[r*SW + b])
                exp_mem[req_addr[r*AW +: AW]][b*8 +: 8] = req_wdata[r*DW + b*8 +: 8];
          end else begin
            sb.push_back(exp_mem[req_addr[r*AW +: AW]]);
            nxt[r] = 1'b1;
          end
        end
      end
      exp_rv = nxt;
    end
  end

  initial begin
    logic [1:0] acc;
    for (int i = 0; i < (1<<AW); i++) begin
      mem[i]     = '0;
      exp_mem[i] = '0;
    end
    arst_n = 1'b0;
    idle();
    // Requests held during reset must not reach the RAM.
    set_req(0, 1'b1, 1'b1, 10'd3, 32'hDEAD_BEEF, 4'hF);
    set_req(1, 1'b1, 1'b0, 10'd4, '0, '0);
    #3;
    chk("reset_rvalid", {62'd0, rsp_rvalid}, 64'd0);
    chk("reset_w_en",   {60'd0, ram_w_en},   64'd0);
    chk("reset_r_en",   {63'd0, ram_r_en},   64'd0);
    chk("reset_ready",  {62'd0, req_ready},  64'd0);
    step();
    step();
    idle();
    arst_n = 1'b1;
    step();

    // Write contention straight out of reset: 0,1,0,1.
    set_req(0, 1'b1, 1'b1, 10'd1, 32'h0000_0101, 4'hF);
    set_req(1, 1'b1, 1'b1, 10'd2, 32'h0000_0202, 4'hF);
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("wr_cont_ready", {62'd0, req_ready},  (i % 2 == 1) ? 64'd2 : 64'd1);
      chk("wr_cont_addr",  {54'd0, ram_w_addr}, (i % 2 == 1) ? 64'd2 : 64'd1);
      step();
    end
    idle();

    // Write then read back.
    set_req(0, 1'b1, 1'b1, 10'd3, 32'hA5A5_A5A5, 4'hF);
    #2;
    chk("wr3_ready", {62'd0, req_ready}, 64'd1);
    chk("wr3_w_en",  {60'd0, ram_w_en},  64'hF);
    step();
    set_req(0, 1'b1, 1'b0, 10'd3, '0, '0);
    #2;
    chk("rd3_ready", {62'd0, req_ready}, 64'd1);
    chk("rd3_r_en",  {63'd0, ram_r_en},  64'd1);
    step();
    idle();
    #2;
    chk("rd3_rvalid", {62'd0, rsp_rvalid}, 64'd1);
    chk("rd3_rdata",  {32'd0, rsp_rdata},  64'hA5A5_A5A5);
    step();

    // Byte strobes.
    set_req(0, 1'b1, 1'b1, 10'd5, 32'h1122_3344, 4'hF);
    step();
    set_req(0, 1'b1, 1'b1, 10'd5, 32'hFFFF_FFFF, 4'h2);
    #2;
    chk("strb_w_en", {60'd0, ram_w_en}, 64'h2);
    step();
    set_req(0, 1'b1, 1'b0, 10'd5, '0, '0);
    step();
    idle();
    #2;
    chk("strb_rdata", {32'd0, rsp_rdata}, 64'h1122_FF44);
    step();

    // Parallel ports.
    set_req(0, 1'b1, 1'b1, 10'd7, 32'h0000_0077, 4'hF);
    set_req(1, 1'b1, 1'b0, 10'd8, '0, '0);
    #2;
    chk("par_ready", {62'd0, req_ready}, 64'd3);
    step();
    idle();
    #2;
    chk("par_rvalid", {62'd0, rsp_rvalid}, 64'd2);
    step();

    // Read-after-write hazard.
    set_req(0, 1'b1, 1'b1, 10'd9, 32'h0000_0055, 4'hF);
    set_req(1, 1'b1, 1'b0, 10'd9, '0, '0);
    #2;
    chk("haz_ready", {62'd0, req_ready}, 64'd1);
    chk("haz_r_en",  {63'd0, ram_r_en},  64'd0);
    step();
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    #2;
    chk("haz_ready_next", {62'd0, req_ready}, 64'd2);
    step();
    idle();
    #2;
    chk("haz_rvalid", {62'd0, rsp_rvalid}, 64'd2);
    chk("haz_rdata",  {32'd0, rsp_rdata},  64'h55);
    step();

    // Reset mid-read, then master 0 must win a read contention.
    set_req(0, 1'b1, 1'b0, 10'd3, '0, '0);
    #2;
    chk("mid_rd_ready", {62'd0, req_ready}, 64'd1);
    step();
    idle();
    arst_n = 1'b0;
    #2;
    chk("mid_rst_rvalid", {62'd0, rsp_rvalid}, 64'd0);
    step();
    step();
    arst_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 10'd3, '0, '0);
    set_req(1, 1'b1, 1'b0, 10'd5, '0, '0);
    #2;
    chk("post_rst_ready", {62'd0, req_ready}, 64'd1);
    step();
    idle();
    step();

    // Random traffic over a small address range, requests held until accepted.
    acc = 2'b00;
    for (int c = 0; c < 200; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!req_valid[r] || acc[r]) begin
          if ($urandom_range(0, 3) == 0)
            set_req(r, 1'b0, 1'b0, '0, '0, '0);
          else
            set_req(r, 1'b1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)),
                    32'($urandom), 4'($urandom_range(0, 15)));
        end
      end
      #2;
      acc = req_valid & req_ready;
      step();
    end
    idle();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
